// File: rtl/mbist_march_ctrl.sv
// -----------------------------------------------------------------------------
// mbist_march_ctrl
//
// Purpose:
//   MBIST engine that runs a March C- test over words 0..MEM_SIZE-1 of a
//   synchronous single-port memory and logs the mismatching reads for the
//   repair logic.
//
//   March elements (element code -> operation):
//     0 : any-order w0        (ascending)
//     1 : up   (r0,w1)
//     2 : up   (r1,w0)
//     3 : down (r0,w1)
//     4 : down (r1,w0)
//     5 : any-order r0        (ascending)
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            level; accepted only while idle
//   busy             high while the march runs
//   done             sticky completion flag, cleared by the next accepted start
//   pass             done and no mismatches
//   fail_cnt         saturating count of mismatching reads
//   first_fail_addr  address of the first mismatch
//   first_fail_elem  march element of the first mismatch
//   first_fail_data  read data captured at the first mismatch
//   mem_en, mem_we   memory enable / write enable
//   mem_addr         memory address
//   mem_wdata        write data (all-0 or all-1 background)
//   mem_rdata        read data, valid the cycle after a read is issued
// -----------------------------------------------------------------------------
module mbist_march_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 256,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [2:0]            first_fail_elem,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                 state_r;
  logic [2:0]             elem_r;
  logic                   seen_r;

  logic [DATA_WIDTH-1:0]  exp_s;
  logic                   desc_s;
  logic                   last_addr_s;
  logic [ADDR_WIDTH-1:0]  next_addr_s;
  logic                   mismatch_s;
  logic [CNT_WIDTH-1:0]   fail_cnt_nxt_s;
  logic [2:0]             next_elem_s;

  // First address visited by an element: descending elements begin at the top.
  function automatic logic [ADDR_WIDTH-1:0] elem_start_addr(input logic [2:0] elem);
    logic [ADDR_WIDTH-1:0] a;
    case (elem)
      3'd3, 3'd4: a = LAST_ADDR;
      default:    a = '0;
    endcase
    return a;
  endfunction

  // Expected read background, direction and address/fail-count updates.
  always_comb begin
    exp_s          = '0;
    desc_s         = 1'b0;
    case (elem_r)
      3'd2, 3'd4: exp_s = '1;
      default:    exp_s = '0;
    endcase
    case (elem_r)
      3'd3, 3'd4: desc_s = 1'b1;
      default:    desc_s = 1'b0;
    endcase
    if (desc_s) begin
      last_addr_s = (mem_addr == '0);
      next_addr_s = mem_addr - ADDR_WIDTH'(1);
    end else begin
      last_addr_s = (mem_addr == LAST_ADDR);
      next_addr_s = mem_addr + ADDR_WIDTH'(1);
    end
    mismatch_s  = (mem_rdata != exp_s);
    next_elem_s = elem_r + 3'd1;
    if (mismatch_s && (fail_cnt != '1)) begin
      fail_cnt_nxt_s = fail_cnt + CNT_WIDTH'(1);
    end else begin
      fail_cnt_nxt_s = fail_cnt;
    end
  end

  // March sequencer: state, element/address tracking, memory port and fail log.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      elem_r          <= 3'd0;
      seen_r          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_elem <= 3'd0;
      first_fail_data <= '0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (start) begin
            fail_cnt        <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= 3'd0;
            first_fail_data <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            seen_r          <= 1'b0;
            busy            <= 1'b1;
            elem_r          <= 3'd0;
            mem_addr        <= '0;
            // The first w0 is already on the port in the first busy cycle.
            mem_en          <= 1'b1;
            mem_we          <= 1'b1;
            mem_wdata       <= '0;
            state_r         <= S_WR;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WR: begin
          if (mem_addr == LAST_ADDR) begin
            elem_r   <= 3'd1;
            mem_addr <= '0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            state_r  <= S_RD;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            mem_en   <= 1'b1;
            mem_we   <= 1'b1;
            state_r  <= S_WR;
          end
        end
        S_RD: begin
          // The CMP cycle carries the write-back of the complemented background.
          if (elem_r == 3'd5) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= ~exp_s;
          end
          state_r <= S_CMP;
        end
        S_CMP: begin
          fail_cnt <= fail_cnt_nxt_s;
          if (mismatch_s && !seen_r) begin
            seen_r          <= 1'b1;
            first_fail_addr <= mem_addr;
            first_fail_elem <= elem_r;
            first_fail_data <= mem_rdata;
          end else begin
            seen_r <= seen_r;
          end
          if (last_addr_s && (elem_r == 3'd5)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (fail_cnt_nxt_s == '0);
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            state_r <= S_DONE;
          end else if (last_addr_s) begin
            elem_r   <= next_elem_s;
            mem_addr <= elem_start_addr(next_elem_s);
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            state_r  <= S_RD;
          end else begin
            mem_addr <= next_addr_s;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            state_r  <= S_RD;
          end
        end
        S_DONE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start_sat;
  logic       stuck;

  // Main instance: MEM_SIZE=16, CNT_WIDTH=8
  logic       busy, done, pass;
  logic [7:0] fail_cnt;
  logic [7:0] ff_addr;
  logic [2:0] ff_elem;
  logic [7:0] ff_data;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  // Saturation instance: CNT_WIDTH=2, memory reads always 0xAA
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_fail_cnt;
  logic [7:0] s_ff_addr;
  logic [2:0] s_ff_elem;
  logic [7:0] s_ff_data;
  logic       s_mem_en, s_mem_we;
  logic [7:0] s_mem_addr, s_mem_wdata;
  logic [7:0] s_mem_rdata;

  logic [7:0] mem [0:15];

  int checks;
  int fails;
  int cyc;
  int busy_cycles;
  logic [7:0] c1_fail;
  logic       c1_done;
  logic       t_en [1:400];
  logic       t_we [1:400];
  logic [7:0] t_addr [1:400];
  logic [7:0] t_wdata [1:400];
  logic       ok;

  assign s_mem_rdata = 8'hAA;

  mbist_march_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_SIZE(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_addr(ff_addr), .first_fail_elem(ff_elem), .first_fail_data(ff_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mbist_march_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_SIZE(16), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail_cnt(s_fail_cnt),
    .first_fail_addr(s_ff_addr), .first_fail_elem(s_ff_elem), .first_fail_data(s_ff_data),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model with optional bit0 stuck-at-1 at address 5
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[3:0]] | {7'd0, (stuck && mem_addr == 8'd5)};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run on the main instance and trace the port until busy drops.
  task automatic run(input int pulse_at, input int abort_at);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c1_fail = fail_cnt;
    c1_done = done;
    cyc = 1;
    while (busy && cyc < 400) begin
      t_en[cyc]    = mem_en;
      t_we[cyc]    = mem_we;
      t_addr[cyc]  = mem_addr;
      t_wdata[cyc] = mem_wdata;
      start = (cyc == pulse_at);
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    busy_cycles = cyc - 1;
  endtask

  initial begin
    checks = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; start_sat = 1'b0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done_pass", {done, pass}, 0);
    check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_log", {fail_cnt, ff_addr, ff_elem, ff_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run
    run(0, 0);
    check("clean_busy_cycles", busy_cycles, 176);
    check("clean_done_pass", {done, pass, busy}, 3'b110);
    check("clean_fail_cnt", fail_cnt, 0);
    ok = 1'b1;
    for (int c = 1; c <= 16; c++)
      if (!(t_en[c] && t_we[c] && t_addr[c] == 8'(c - 1) && t_wdata[c] == 8'h00)) ok = 1'b0;
    check("w0_phase", ok, 1);
    check("first_read", {t_en[17], t_we[17], t_addr[17]}, {1'b1, 1'b0, 8'd0});
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (!(t_en[81+2*k] && !t_we[81+2*k] && t_addr[81+2*k] == 8'(15 - k))) ok = 1'b0;
      if (!(t_en[82+2*k] && t_we[82+2*k] && t_addr[82+2*k] == 8'(15 - k) && t_wdata[82+2*k] == 8'hFF)) ok = 1'b0;
    end
    check("elem3_seq", ok, 1);
    check("elem4_start", {t_en[113], t_we[113], t_addr[113]}, {1'b1, 1'b0, 8'd15});
    check("elem5_cmp_idle", {t_en[146], t_we[146]}, 2'b00);
    ok = 1'b1;
    for (int c = 1; c <= 176; c++) begin
      if (t_we[c] && !t_en[c]) ok = 1'b0;
      if (t_en[c] && t_addr[c] >= 8'd16) ok = 1'b0;
    end
    check("port_protocol", ok, 1);
    repeat (3) @(negedge clk);
    check("done_sticky", {done, pass}, 2'b11);

    // Stuck-at-1 on bit0 at address 5
    stuck = 1'b1;
    run(0, 0);
    stuck = 1'b0;
    check("fault_done_pass", {done, pass}, 2'b10);
    check("fault_fail_cnt", fail_cnt, 3);
    check("fault_ff_addr", ff_addr, 5);
    check("fault_ff_elem", ff_elem, 1);
    check("fault_ff_data", ff_data, 8'h01);

    // start pulse during busy cycle 50 must be ignored
    run(50, 0);
    check("restart_clears_log", {c1_done, c1_fail}, 0);
    check("ignore_busy_cycles", busy_cycles, 176);
    check("ignore_result", {done, pass, fail_cnt}, {1'b1, 1'b1, 8'd0});
    repeat (2) @(negedge clk);
    check("ignore_no_rerun", busy, 0);

    // Saturating counter, memory always reads 0xAA
    @(negedge clk) start_sat = 1'b1;
    @(negedge clk) start_sat = 1'b0;
    cyc = 1;
    while (s_busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_busy_cycles", cyc - 1, 176);
    check("sat_fail_cnt", s_fail_cnt, 3);
    check("sat_ff", {s_ff_addr, s_ff_elem, s_ff_data}, {8'd0, 3'd1, 8'hAA});
    check("sat_done_pass", {s_done, s_pass}, 2'b10);

    // Reset at busy cycle 80
    run(0, 80);
    #1;
    check("abort_busy_mem", {busy, mem_en, mem_we, mem_addr}, 0);
    check("abort_status", {done, pass, fail_cnt, ff_addr}, 0);
    @(negedge clk) rst_n = 1'b1;
    run(0, 0);
    check("post_abort_cycles", busy_cycles, 176);
    check("post_abort_result", {done, pass, fail_cnt}, {1'b1, 1'b1, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
